// File: rtl/painterengine_gpu_writer_fifo_pkg.sv
// Shared widths and defaults for the GPU DMA writer word FIFO.
// One FIFO word carries one 32-bit render word or two packed RGB565 pixels.
package painterengine_gpu_writer_fifo_pkg;

    localparam int GPU_DATA_W          = 32;
    localparam int GPU_PIX_W           = 16;
    localparam int GPU_FIFO_DEPTH_LOG2 = 5;
    localparam int GPU_FIFO_ALMOST_FULL = 28;

    // Even pixel sits in the low half so memory order matches pixel order.
    function automatic logic [GPU_DATA_W-1:0] pack565(input logic [GPU_PIX_W-1:0] even_pix,
                                                     input logic [GPU_PIX_W-1:0] odd_pix);
        return {odd_pix, even_pix};
    endfunction

endpackage

// File: rtl/painterengine_gpu_fifo_ram.sv
// Word storage for the writer FIFO: one synchronous write port, one asynchronous read port.
// Read data follows rd_addr combinationally; no reset, contents are qualified by the FIFO level.
module painterengine_gpu_fifo_ram
    import painterengine_gpu_writer_fifo_pkg::*;
#(
    parameter int ADDR_W = GPU_FIFO_DEPTH_LOG2
) (
    input  logic                  i_wire_clock,
    input  logic                  wr_vld,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [GPU_DATA_W-1:0] wr_dat,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [GPU_DATA_W-1:0] rd_dat
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [GPU_DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge i_wire_clock) begin
        if (wr_vld) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/painterengine_gpu_writer_fifo.sv
// Show-ahead word FIFO feeding the GPU DMA writer data port; optional RGB565 pair packing (PAINTERENGINE_GPU_FIFO_PACK565_EN).
// Latency: accepted push visible on o_wire_data_valid one cycle later; pop reveals the new head next cycle.
// Backpressure: push_ready drops at DEPTH words and a same-cycle pop only reopens it on the following cycle.
module painterengine_gpu_writer_fifo
    import painterengine_gpu_writer_fifo_pkg::*;
#(
    parameter int PARAM_DEPTH_LOG2  = GPU_FIFO_DEPTH_LOG2,
    parameter int PARAM_ALMOST_FULL = GPU_FIFO_ALMOST_FULL
) (
    input  logic                        i_wire_clock,
    input  logic                        i_wire_resetn,
    input  logic                        i_wire_clear,
    input  logic [GPU_DATA_W-1:0]       i_wire_push_data,
    input  logic                        i_wire_push_valid,
    output logic                        o_wire_push_ready,
    output logic [GPU_DATA_W-1:0]       o_wire_data,
    output logic                        o_wire_data_valid,
    input  logic                        i_wire_data_next,
    output logic [PARAM_DEPTH_LOG2:0]   o_wire_level,
    output logic                        o_wire_almost_full,
    output logic                        o_wire_underflow
);

    localparam int DEPTH = 2 ** PARAM_DEPTH_LOG2;
    localparam int LVL_W = PARAM_DEPTH_LOG2 + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(PARAM_ALMOST_FULL);

    logic [PARAM_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [PARAM_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]            level_q, level_d;
    logic                        underflow_q, underflow_d;

    logic                  push_acc;
    logic                  pop_acc;
    logic                  word_wr_vld;
    logic [GPU_DATA_W-1:0] word_wr_dat;
    logic [GPU_DATA_W-1:0] ram_rd_dat;

    assign o_wire_push_ready  = (level_q != LVL_FULL);
    assign o_wire_data_valid  = (level_q != '0);
    assign o_wire_almost_full = (level_q >= LVL_AF);
    assign o_wire_level       = level_q;
    assign o_wire_underflow   = underflow_q;
    assign o_wire_data        = o_wire_data_valid ? ram_rd_dat : '0;

    assign push_acc = i_wire_push_valid && o_wire_push_ready && !i_wire_clear;
    assign pop_acc  = i_wire_data_next && o_wire_data_valid && !i_wire_clear;

`ifdef PAINTERENGINE_GPU_FIFO_PACK565_EN
    logic [GPU_PIX_W-1:0] half_q, half_d;
    logic                 half_vld_q, half_vld_d;

    // Only the odd pixel of a pair produces a stored word.
    assign word_wr_vld = push_acc && half_vld_q;
    assign word_wr_dat = pack565(half_q, i_wire_push_data[GPU_PIX_W-1:0]);

    always_comb begin
        half_d     = half_q;
        half_vld_d = half_vld_q;
        if (i_wire_clear) begin
            half_d     = '0;
            half_vld_d = 1'b0;
        end else if (push_acc) begin
            half_vld_d = !half_vld_q;
            if (!half_vld_q) begin
                half_d = i_wire_push_data[GPU_PIX_W-1:0];
            end
        end
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            half_q     <= '0;
            half_vld_q <= 1'b0;
        end else begin
            half_q     <= half_d;
            half_vld_q <= half_vld_d;
        end
    end
`else
    assign word_wr_vld = push_acc;
    assign word_wr_dat = i_wire_push_data;
`endif

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        underflow_d = underflow_q;
        if (i_wire_clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            underflow_d = 1'b0;
        end else begin
            if (word_wr_vld) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            level_d = level_q + LVL_W'(word_wr_vld) - LVL_W'(pop_acc);
            if (i_wire_data_next && !o_wire_data_valid) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            underflow_q <= underflow_d;
        end
    end

    painterengine_gpu_fifo_ram #(
        .ADDR_W (PARAM_DEPTH_LOG2)
    ) u_ram (
        .i_wire_clock (i_wire_clock),
        .wr_vld       (word_wr_vld),
        .wr_addr      (wr_ptr_q),
        .wr_dat       (word_wr_dat),
        .rd_addr      (rd_ptr_q),
        .rd_dat       (ram_rd_dat)
    );

endmodule

// File: tb/tb_painterengine_gpu_writer_fifo.sv
// Scoreboard bench for painterengine_gpu_writer_fifo; a queue model tracks stored words and flags.
module tb_painterengine_gpu_writer_fifo;

    localparam int DEPTH = 32;
    localparam int AF    = 28;
`ifdef PAINTERENGINE_GPU_FIFO_PACK565_EN
    localparam int PPW = 2;
`else
    localparam int PPW = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] pd = '0;
    logic        pv = 1'b0;
    logic        nx = 1'b0;
    logic        ready;
    logic [31:0] data;
    logic        valid;
    logic [5:0]  level;
    logic        af;
    logic        uf;

    painterengine_gpu_writer_fifo dut (
        .i_wire_clock       (clk),
        .i_wire_resetn      (rst_n),
        .i_wire_clear       (clr),
        .i_wire_push_data   (pd),
        .i_wire_push_valid  (pv),
        .o_wire_push_ready  (ready),
        .o_wire_data        (data),
        .o_wire_data_valid  (valid),
        .i_wire_data_next   (nx),
        .o_wire_level       (level),
        .o_wire_almost_full (af),
        .o_wire_underflow   (uf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_q[$];
    bit          m_half_vld = 1'b0;
    logic [15:0] m_half = '0;
    bit          m_uf = 1'b0;
    int          m_sz;
    bit          m_push, m_pop;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare the DUT against the model, then advance the model with this cycle's inputs.
    always @(negedge clk) begin
        if (rst_n) begin
            m_sz = exp_q.size();
            chk("valid", 32'(valid), 32'(m_sz != 0));
            chk("head_data", data, (m_sz != 0) ? exp_q[0] : 32'h0);
            chk("level", 32'(level), 32'(m_sz));
            chk("push_ready", 32'(ready), 32'(m_sz != DEPTH));
            chk("almost_full", 32'(af), 32'(m_sz >= AF));
            chk("underflow", 32'(uf), 32'(m_uf));
            if (clr) begin
                exp_q.delete();
                m_half_vld = 1'b0;
                m_half = '0;
                m_uf = 1'b0;
            end else begin
                m_push = pv && (m_sz != DEPTH);
                m_pop  = nx && (m_sz != 0);
                if (nx && m_sz == 0) m_uf = 1'b1;
                if (m_pop) void'(exp_q.pop_front());
                if (m_push) begin
`ifdef PAINTERENGINE_GPU_FIFO_PACK565_EN
                    if (!m_half_vld) begin
                        m_half = pd[15:0];
                        m_half_vld = 1'b1;
                    end else begin
                        exp_q.push_back({pd[15:0], m_half});
                        m_half_vld = 1'b0;
                    end
`else
                    exp_q.push_back(pd);
`endif
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [31:0] d, input bit n, output bit acc);
        pv = v;
        pd = d;
        nx = n;
        @(negedge clk);
        acc = v && ready;
        @(posedge clk);
        #1;
    endtask

    task automatic push_item(input logic [31:0] d);
        bit acc;
        int t;
        t = 0;
        acc = 1'b0;
        while (!acc && t < 64) begin
            drive(1'b1, d, 1'b0, acc);
            t++;
        end
        pv = 1'b0;
        chk("push_accepted", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, acc);
    endtask

    task automatic clear_cycle();
        bit acc;
        clr = 1'b1;
        drive(1'b0, 32'h0, 1'b0, acc);
        clr = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int t;
        t = 0;
        while (valid && t < 200) begin
            drive(1'b0, 32'h0, 1'b1, acc);
            t++;
        end
        nx = 1'b0;
        chk("drain_empty", 32'(valid), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit acc;
        int cnt;
        int idx;
        int t;

        #1;
        chk("rst_data", data, 32'h0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_af", 32'(af), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        push_item(32'hA0);
        push_item(32'hA1);
        push_item(32'hA2);
`ifdef PAINTERENGINE_GPU_FIFO_PACK565_EN
        chk("three_push_level", 32'(level), 32'd1);
        chk("three_push_data", data, 32'h00A1_00A0);
`else
        chk("three_push_level", 32'(level), 32'd3);
        chk("three_push_data", data, 32'h0000_00A0);
`endif
        chk("three_push_valid", 32'(valid), 32'd1);
        clear_cycle();
        chk("clear_level", 32'(level), 32'd0);

        for (int i = 0; i < DEPTH * PPW; i++) push_item(32'(i));
        chk("full_ready", 32'(ready), 32'd0);
        chk("full_level", 32'(level), 32'(DEPTH));
        chk("full_af", 32'(af), 32'd1);

        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h0000_0040, 1'b0, acc);
            if (acc) cnt++;
        end
        chk("stall_while_full", 32'(cnt), 32'd0);

        // Pop while the stalled item(s) keep retrying; they must land after word 31.
        idx = 0;
        t = 0;
        while ((idx < PPW || valid) && t < 200) begin
            drive(idx < PPW, 32'h0000_0040 + 32'(idx), valid, acc);
            if (acc) idx++;
            t++;
        end
        pv = 1'b0;
        nx = 1'b0;
        chk("stalled_pushed", 32'(idx), 32'(PPW));
        chk("drained_level", 32'(level), 32'd0);
        chk("drained_underflow", 32'(uf), 32'd0);

        for (int i = 0; i < 5 * PPW; i++) push_item(32'h100 + 32'(i));
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, $urandom, (i % PPW) == (PPW - 1), acc);
        end
        pv = 1'b0;
        nx = 1'b0;
        chk("steady_level", 32'(level), 32'd5);
        drain();

        for (int i = 0; i < 400; i++) begin
            clr = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) == 0, acc);
        end
        clr = 1'b0;
        pv = 1'b0;
        nx = 1'b0;
        clear_cycle();

        drive(1'b0, 32'h0, 1'b1, acc);
        nx = 1'b0;
        chk("underflow_set", 32'(uf), 32'd1);
        idle(3);
        chk("underflow_sticky", 32'(uf), 32'd1);
        clear_cycle();
        chk("underflow_cleared", 32'(uf), 32'd0);
        chk("underflow_clear_level", 32'(level), 32'd0);

`ifdef PAINTERENGINE_GPU_FIFO_PACK565_EN
        push_item(32'h0000_1234);
        push_item(32'h0000_ABCD);
        chk("pack_word", data, 32'hABCD_1234);
        chk("pack_level", 32'(level), 32'd1);
        clear_cycle();
        push_item(32'h0000_5555);
        chk("half_invisible", 32'(level), 32'd0);
        clear_cycle();
        chk("half_clear_level", 32'(level), 32'd0);
        push_item(32'h0000_1111);
        push_item(32'h0000_2222);
        chk("repack_word", data, 32'h2222_1111);
`else
        push_item(32'h0000_1234);
        push_item(32'h0000_ABCD);
        chk("word_head", data, 32'h0000_1234);
        chk("word_level", 32'(level), 32'd2);
`endif
        drain();
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
